// File: rtl/upstream_risk_tracker_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : upstream_risk_tracker_if                               |
// | Description : Request/response bundle between order ingress and the  |
// |               per-client risk tracker.                               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface upstream_risk_tracker_if #(
  parameter int CLIENT_BITS = 5,
  parameter int AMT_W       = 32,
  parameter int CNT_W       = 16
);
  // request side
  logic [CLIENT_BITS-1:0] client_id;
  logic [AMT_W-1:0]       amount;
  logic                   new_order;
  logic                   new_max;
  logic                   req_ready;
  // response side
  logic                   resp_valid;
  logic                   resp_accept;
  logic                   thenewmax;
  logic [CLIENT_BITS-1:0] resp_client;
  logic [AMT_W-1:0]       accumulated_orders;
  logic [AMT_W-1:0]       max_to_trade;
  logic [CNT_W-1:0]       reject_count;

  // request issuer / response consumer
  modport master (
    output client_id, amount, new_order, new_max,
    input  req_ready, resp_valid, resp_accept, thenewmax, resp_client,
           accumulated_orders, max_to_trade, reject_count
  );

  // the tracker itself
  modport slave (
    input  client_id, amount, new_order, new_max,
    output req_ready, resp_valid, resp_accept, thenewmax, resp_client,
           accumulated_orders, max_to_trade, reject_count
  );
endinterface
`default_nettype wire

// File: rtl/upstream_risk_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : upstream_risk_tracker                                  |
// | Description : Per-client accumulated order total and trade limit.    |
// |               Each order is checked against the client's limit and   |
// |               committed only if it fits; limits may be set at will.  |
// |               One request per four cycles, ready/response handshake. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module upstream_risk_tracker #(
  parameter int CLIENT_BITS = 5,
  parameter int AMT_W       = 32,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  upstream_risk_tracker_if.slave bus
);

  localparam int NCLI = 1 << CLIENT_BITS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_UPDATE = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                 state_q, state_d;

  // captured request
  logic [CLIENT_BITS-1:0] req_id_q, req_id_d;
  logic [AMT_W-1:0]       req_amt_q, req_amt_d;
  logic                   req_max_q, req_max_d;

  // operands read in READ, overwritten with post-update values in UPDATE
  logic [AMT_W-1:0]       op_acc_q, op_acc_d;
  logic [AMT_W-1:0]       op_lim_q, op_lim_d;
  logic                   op_ok_q, op_ok_d;

  // per-client storage
  logic [AMT_W-1:0]       acc_q [NCLI];
  logic [AMT_W-1:0]       acc_d [NCLI];
  logic [AMT_W-1:0]       lim_q [NCLI];
  logic [AMT_W-1:0]       lim_d [NCLI];

  // response registers; hold between responses
  logic                   resp_valid_q, resp_valid_d;
  logic                   resp_accept_q, resp_accept_d;
  logic                   thenewmax_q, thenewmax_d;
  logic [CLIENT_BITS-1:0] resp_client_q, resp_client_d;
  logic [AMT_W-1:0]       acc_out_q, acc_out_d;
  logic [AMT_W-1:0]       lim_out_q, lim_out_d;
  logic [CNT_W-1:0]       reject_count_q, reject_count_d;

  // carry bit catches wrap-around of the running total
  logic [AMT_W:0]         sum;
  logic                   order_fits;

  // order fits if it neither overflows nor exceeds the limit (equality accepted)
  always_comb begin
    sum        = {1'b0, op_acc_q} + {1'b0, req_amt_q};
    order_fits = !sum[AMT_W] && (sum[AMT_W-1:0] <= op_lim_q);
  end

  // next-state and datapath: capture, read, commit-or-reject, respond
  always_comb begin
    state_d        = state_q;
    req_id_d       = req_id_q;
    req_amt_d      = req_amt_q;
    req_max_d      = req_max_q;
    op_acc_d       = op_acc_q;
    op_lim_d       = op_lim_q;
    op_ok_d        = op_ok_q;
    acc_d          = acc_q;
    lim_d          = lim_q;
    resp_valid_d   = 1'b0;
    resp_accept_d  = resp_accept_q;
    thenewmax_d    = thenewmax_q;
    resp_client_d  = resp_client_q;
    acc_out_d      = acc_out_q;
    lim_out_d      = lim_out_q;
    reject_count_d = reject_count_q;

    case (state_q)
      S_IDLE: begin
        if (bus.new_order || bus.new_max) begin
          req_id_d  = bus.client_id;
          req_amt_d = bus.amount;
          // a max strobe wins over a simultaneous order strobe
          req_max_d = bus.new_max;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        op_acc_d = acc_q[req_id_q];
        op_lim_d = lim_q[req_id_q];
        state_d  = S_UPDATE;
      end
      S_UPDATE: begin
        if (req_max_q) begin
          // limit may drop below the current total; total untouched
          lim_d[req_id_q] = req_amt_q;
          op_lim_d        = req_amt_q;
          op_ok_d         = 1'b1;
        end else if (order_fits) begin
          acc_d[req_id_q] = sum[AMT_W-1:0];
          op_acc_d        = sum[AMT_W-1:0];
          op_ok_d         = 1'b1;
        end else begin
          op_ok_d = 1'b0;
          if (reject_count_q != {CNT_W{1'b1}}) begin
            reject_count_d = reject_count_q + CNT_W'(1);
          end
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid_d  = 1'b1;
        resp_accept_d = op_ok_q;
        thenewmax_d   = req_max_q;
        resp_client_d = req_id_q;
        acc_out_d     = op_acc_q;
        lim_out_d     = op_lim_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and storage registers; reset abandons any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      req_id_q       <= '0;
      req_amt_q      <= '0;
      req_max_q      <= 1'b0;
      op_acc_q       <= '0;
      op_lim_q       <= '0;
      op_ok_q        <= 1'b0;
      for (int i = 0; i < NCLI; i++) begin
        acc_q[i] <= '0;
        lim_q[i] <= '0;
      end
      resp_valid_q   <= 1'b0;
      resp_accept_q  <= 1'b0;
      thenewmax_q    <= 1'b0;
      resp_client_q  <= '0;
      acc_out_q      <= '0;
      lim_out_q      <= '0;
      reject_count_q <= '0;
    end else begin
      state_q        <= state_d;
      req_id_q       <= req_id_d;
      req_amt_q      <= req_amt_d;
      req_max_q      <= req_max_d;
      op_acc_q       <= op_acc_d;
      op_lim_q       <= op_lim_d;
      op_ok_q        <= op_ok_d;
      acc_q          <= acc_d;
      lim_q          <= lim_d;
      resp_valid_q   <= resp_valid_d;
      resp_accept_q  <= resp_accept_d;
      thenewmax_q    <= thenewmax_d;
      resp_client_q  <= resp_client_d;
      acc_out_q      <= acc_out_d;
      lim_out_q      <= lim_out_d;
      reject_count_q <= reject_count_d;
    end
  end

  assign bus.req_ready          = (state_q == S_IDLE);
  assign bus.resp_valid         = resp_valid_q;
  assign bus.resp_accept        = resp_accept_q;
  assign bus.thenewmax          = thenewmax_q;
  assign bus.resp_client        = resp_client_q;
  assign bus.accumulated_orders = acc_out_q;
  assign bus.max_to_trade       = lim_out_q;
  assign bus.reject_count       = reject_count_q;

endmodule
`default_nettype wire

// File: doc/upstream_risk_tracker.md
Name: upstream_risk_tracker

Overview:
Parametrised successor to the upstream processor top. Keeps a per-client accumulated order total and a per-client max-to-trade limit, and checks each new order against that client's limit before committing it. Rejected orders leave state unchanged. Sits on the upstream path between order ingress and the downstream trade path, and gives a ready/response handshake in place of fixed-wait strobes.

Parameters:
CLIENT_BITS, 5, client_id width; number of clients NCLI = 2**CLIENT_BITS
AMT_W, 32, width of amount, accumulated total and limit
CNT_W, 16, width of the saturating reject counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
client_id  in  CLIENT_BITS  client addressed by the request
amount  in  AMT_W  order quantity (order op) or new limit (max op)
new_order  in  1  request strobe: order op
new_max  in  1  request strobe: set-limit op
req_ready  out  1  high when a request can be accepted
resp_valid  out  1  one-cycle pulse: response fields valid
resp_accept  out  1  1 = op committed, 0 = order rejected
thenewmax  out  1  1 = response belongs to a max op
resp_client  out  CLIENT_BITS  client_id of the responded request
accumulated_orders  out  AMT_W  client's total after the op
max_to_trade  out  AMT_W  client's limit after the op
reject_count  out  CNT_W  total rejected orders, saturating

Behaviour:
- Reset (async assert, clock-synchronous release): all acc[i]=0 and lim[i]=0; FSM=IDLE; req_ready=1; resp_valid=0; resp_accept=0; thenewmax=0; resp_client=0; accumulated_orders=0; max_to_trade=0; reject_count=0.
- Storage: two register arrays of NCLI x AMT_W. Only the UPDATE state writes them.
- FSM states and transitions:
  - IDLE: req_ready=1. A request is taken at a rising edge where (new_order|new_max)=1. On that edge, latch client_id, amount and the op into request registers, then go to READ.
  - READ: req_ready=0. Latch acc[id] and lim[id] into operand registers. Go to UPDATE.
  - UPDATE: req_ready=0.
    - Max op: lim[id]=amount; accept=1. Lowering the limit below the current total is allowed; acc is unchanged.
    - Order op: sum = acc+amount computed at AMT_W+1 bits. If sum[AMT_W]==0 and sum<=lim, set acc[id]=sum and accept=1. Otherwise no write, accept=0, and reject_count increments (holds at all-ones).
    - Go to RESP.
  - RESP: resp_valid=1 for this cycle only. resp_accept, thenewmax, resp_client, accumulated_orders and max_to_trade show post-update values. Go to IDLE.
- Latency: request sampled at edge E0. resp_valid is high between E3 and E4. req_ready is low from E0 to E3, so back-to-back throughput is one request per 4 cycles.
- Result outputs (accumulated_orders, max_to_trade, resp_accept, thenewmax, resp_client) hold their last response values until the next RESP. Only resp_valid pulses.
- Strobes while req_ready=0 are ignored; nothing is queued. The sender must hold the strobe until it is taken.
- new_order and new_max both high in IDLE: the max op is taken and the order is dropped. The drop does not count as a reject.
- amount=0 order: accepted, total unchanged.
- Accept on equality: sum==lim is accepted.
- Reset during READ/UPDATE/RESP: the operation is abandoned, all state is cleared, and no resp_valid is produced.

Test Plan:
- Reset, then order client 0x01 amount 0x1 -> resp_accept=0, accumulated_orders=0, max_to_trade=0, reject_count=1.
- Max op client 0x1B amount 0xB0C5 -> resp_valid three edges later; thenewmax=1, resp_accept=1, max_to_trade=0xB0C5, req_ready low for exactly 3 cycles.
- Order client 0x1B amount 0x5C5 -> resp_accept=1, accumulated_orders=0x5C5. Then order 0xAB00 -> accepted, total 0xB0C5 (equality). Then order 0x1 -> rejected, total stays 0xB0C5, reject_count +1.
- Limit 0xFFFFFFFF on client 0x02, order 0xFFFFFFFF, then order 0x1 -> second order rejected (overflow); total 0xFFFFFFFF.
- new_order and new_max both high, client 0x03 amount 0x10 -> single response with thenewmax=1, max_to_trade=0x10, reject_count unchanged. Strobe pulsed while busy -> no extra response.
- Assert rst during UPDATE of an order -> all outputs 0 immediately, no resp_valid; a later read-back order to that client shows total 0.
